// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   N-channel arbiter and registered port driver for one single-port SRAM bank.
//   Requesters raise req_i. One channel is granted per cycle, round-robin or by
//   fixed priority. The granted command is registered onto the SRAM pins, and
//   read data comes back to the issuing channel with a latency-matched valid.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_i, wr_i       per-channel request and op (1 = write)
//   addr_i, wdata_i   per-channel address / write data, channel c at [c*W +: W]
//   gnt_o             one-hot combinational grant
//   rvalid_o, rdata_o one-hot read-return valid, shared registered read data
//   sram_*            registered SRAM pins (CEN/WEN active-low), sram_q_i read data
module sram_port_arbiter #(
   parameter int unsigned NCH      = 16,
   parameter int unsigned DW       = 16,
   parameter int unsigned AW       = 10,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned ARB_MODE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH-1:0]    req_i,
   input  logic [NCH-1:0]    wr_i,
   input  logic [NCH*AW-1:0] addr_i,
   input  logic [NCH*DW-1:0] wdata_i,
   output logic [NCH-1:0]    gnt_o,
   output logic [NCH-1:0]    rvalid_o,
   output logic [DW-1:0]     rdata_o,
   output logic              sram_cen_o,
   output logic              sram_wen_o,
   output logic [AW-1:0]     sram_a_o,
   output logic [DW-1:0]     sram_d_o,
   input  logic [DW-1:0]     sram_q_i
);

   localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned NST = RD_LAT + 1;

   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    base;
   logic [2*NCH-1:0] req_dbl;
   logic [NCH-1:0]   req_rot;
   logic [IW:0]      off, sum;
   logic [IW-1:0]    gnt_idx;
   logic             gnt_any;
   logic             sel_wr;
   logic [AW-1:0]    sel_addr;
   logic [DW-1:0]    sel_wdata;

   logic             cen_q, wen_q;
   logic [AW-1:0]    a_q;
   logic [DW-1:0]    d_q;

   logic [NST-1:0]   vld_q;
   logic [IW-1:0]    idx_q [NST];
   logic [NCH-1:0]   rvalid_q, rvalid_d;
   logic [DW-1:0]    rdata_q;

   // Both modes share one search: requests are rotated so the search start sits
   // at bit 0, and fixed priority simply pins the start at channel 0.
   always_comb begin
      base    = (ARB_MODE == 1) ? '0 : ptr_q;
      req_dbl = {req_i, req_i};
      req_rot = req_dbl[base +: NCH];
      off     = '0;
      for (int i = int'(NCH) - 1; i >= 0; i--) begin
         if (req_rot[i]) off = (IW+1)'(i);
      end
      gnt_any = |req_i;
      sum     = {1'b0, base} + off;
      if (sum >= (IW+1)'(NCH)) sum = sum - (IW+1)'(NCH);
      gnt_idx = sum[IW-1:0];
      for (int i = 0; i < int'(NCH); i++) begin
         gnt_o[i] = gnt_any && (gnt_idx == IW'(i));
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (ARB_MODE == 0 && gnt_any) begin
         ptr_d = (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + IW'(1);
      end
   end

   assign sel_wr    = wr_i[gnt_idx];
   assign sel_addr  = addr_i[gnt_idx*AW +: AW];
   assign sel_wdata = wdata_i[gnt_idx*DW +: DW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cen_q <= 1'b1;
         wen_q <= 1'b1;
         a_q   <= '0;
         d_q   <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (gnt_any) begin
            cen_q <= 1'b0;
            wen_q <= ~sel_wr;
            a_q   <= sel_addr;
            // Reads leave the data pins untouched to avoid needless toggling.
            if (sel_wr) d_q <= sel_wdata;
         end else begin
            cen_q <= 1'b1;
            wen_q <= 1'b1;
         end
      end
   end

   // Read tracking: stage 0 lines up with the pin cycle, the last stage with Q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int s = 0; s < int'(NST); s++) idx_q[s] <= '0;
      end else begin
         vld_q[0] <= gnt_any && !sel_wr;
         idx_q[0] <= gnt_idx;
         for (int s = 1; s < int'(NST); s++) begin
            vld_q[s] <= vld_q[s-1];
            idx_q[s] <= idx_q[s-1];
         end
      end
   end

   always_comb begin
      rvalid_d = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         rvalid_d[i] = vld_q[NST-1] && (idx_q[NST-1] == IW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         if (vld_q[NST-1]) rdata_q <= sram_q_i;
      end
   end

   assign sram_cen_o = cen_q;
   assign sram_wen_o = wen_q;
   assign sram_a_o   = a_q;
   assign sram_d_o   = d_q;
   assign rvalid_o   = rvalid_q;
   assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Two arbiters share one set of request inputs: u_rr (round-robin, RD_LAT=1)
//   and u_fp (fixed priority, RD_LAT=3). Each drives its own behavioural SRAM.
module tb_sram_port_arbiter;

   localparam int unsigned NCH = 16;
   localparam int unsigned DW  = 16;
   localparam int unsigned AW  = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    req_i;
   logic [NCH-1:0]    wr_i;
   logic [NCH*AW-1:0] addr_i;
   logic [NCH*DW-1:0] wdata_i;

   logic [NCH-1:0] gnt_r, gnt_f, rv_r, rv_f;
   logic [DW-1:0]  rd_r, rd_f, d_r, d_f, q_r, q_f;
   logic [AW-1:0]  a_r, a_f;
   logic           cen_r, cen_f, wen_r, wen_f;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.NCH(NCH), .DW(DW), .AW(AW), .RD_LAT(1), .ARB_MODE(0)) u_rr (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .gnt_o(gnt_r), .rvalid_o(rv_r), .rdata_o(rd_r),
      .sram_cen_o(cen_r), .sram_wen_o(wen_r), .sram_a_o(a_r), .sram_d_o(d_r),
      .sram_q_i(q_r)
   );

   sram_port_arbiter #(.NCH(NCH), .DW(DW), .AW(AW), .RD_LAT(3), .ARB_MODE(1)) u_fp (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .gnt_o(gnt_f), .rvalid_o(rv_f), .rdata_o(rd_f),
      .sram_cen_o(cen_f), .sram_wen_o(wen_f), .sram_a_o(a_f), .sram_d_o(d_f),
      .sram_q_i(q_f)
   );

   // SRAM models: sample pins on the clock edge, Q appears RD_LAT cycles later.
   logic [DW-1:0] mem_r [0:1023];
   logic [DW-1:0] mem_f [0:1023];
   logic [DW-1:0] qp_f  [0:2];

   always @(posedge clk) begin
      if (!cen_r && !wen_r) mem_r[a_r] <= d_r;
      if (!cen_r && wen_r)  q_r <= mem_r[a_r];
   end

   always @(posedge clk) begin
      if (!cen_f && !wen_f) mem_f[a_f] <= d_f;
      if (!cen_f && wen_f)  qp_f[0] <= mem_f[a_f];
      qp_f[1] <= qp_f[0];
      qp_f[2] <= qp_f[1];
   end
   assign q_f = qp_f[2];

   typedef struct {
      logic [NCH-1:0] req;
      logic [NCH-1:0] gnt_rr;
      logic [NCH-1:0] gnt_fp;
   } arb_vec_t;

   localparam int NV = 29;
   arb_vec_t vecs [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_one(input int ch, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
      req_i                 = '0;
      req_i[ch]             = 1'b1;
      wr_i[ch]              = wr;
      addr_i[ch*AW +: AW]   = a;
      wdata_i[ch*DW +: DW]  = d;
   endtask

   task automatic idle(input int n);
      req_i = '0;
      for (int i = 0; i < n; i++) next_cycle();
   endtask

   logic [NCH-1:0] bb_v [3];
   logic [DW-1:0]  bb_d [3];

   initial begin
      // Vector table: 20-cycle all-request sweep, then gaps and sparse patterns.
      for (int i = 0; i < 20; i++) begin
         vecs[i].req    = 16'hFFFF;
         vecs[i].gnt_rr = 16'h0001 << (i % 16);
         vecs[i].gnt_fp = 16'h0001;
      end
      vecs[20] = '{16'h0000, 16'h0000, 16'h0000};
      vecs[21] = '{16'h0009, 16'h0001, 16'h0001};
      vecs[22] = '{16'h0009, 16'h0008, 16'h0001};
      vecs[23] = '{16'h8000, 16'h8000, 16'h8000};
      vecs[24] = '{16'h0000, 16'h0000, 16'h0000};
      vecs[25] = '{16'h8001, 16'h0001, 16'h0001};
      vecs[26] = '{16'h8000, 16'h8000, 16'h8000};
      vecs[27] = '{16'h0006, 16'h0002, 16'h0002};
      vecs[28] = '{16'h0006, 16'h0004, 16'h0002};

      bb_v[0] = 16'h0002; bb_v[1] = 16'h0004; bb_v[2] = 16'h0002;
      bb_d[0] = 16'h1111; bb_d[1] = 16'h2222; bb_d[2] = 16'h3333;

      // Reset with every channel requesting.
      rst_n   = 1'b0;
      req_i   = '1;
      wr_i    = '0;
      addr_i  = '0;
      wdata_i = '0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst_gnt_rr", 64'(gnt_r), 64'h0001);
      chk("rst_gnt_fp", 64'(gnt_f), 64'h0001);
      chk("rst_cen", 64'({cen_r, cen_f}), 64'h3);
      chk("rst_wen", 64'({wen_r, wen_f}), 64'h3);
      chk("rst_rvalid", 64'({rv_r, rv_f}), 64'h0);
      chk("rst_rdata", 64'({rd_r, rd_f}), 64'h0);
      chk("rst_a_d", 64'({a_r, d_r}), 64'h0);
      rst_n = 1'b1;
      #1;
      chk("rel_gnt_rr", 64'(gnt_r), 64'h0001);
      req_i = '0;
      next_cycle();

      // Arbitration table.
      for (int i = 0; i < NV; i++) begin
         req_i = vecs[i].req;
         @(negedge clk);
         chk($sformatf("arb_rr[%0d]", i), 64'(gnt_r), 64'(vecs[i].gnt_rr));
         chk($sformatf("arb_fp[%0d]", i), 64'(gnt_f), 64'(vecs[i].gnt_fp));
         next_cycle();
      end
      idle(8);

      // Write by ch3, read back by ch7 one cycle later, then idle.
      for (int k = 0; k < 9; k++) begin
         if (k == 0)      drive_one(3, 1'b1, 10'h005, 16'hA5A5);
         else if (k == 1) drive_one(7, 1'b0, 10'h005, 16'h0000);
         else             req_i = '0;
         @(negedge clk);
         if (k == 1) begin
            chk("wr_gnt", 64'({gnt_r, gnt_f}), {32'h0, 16'h0080, 16'h0080});
            chk("wr_pins_rr", 64'({cen_r, wen_r, a_r, d_r}), {36'h0, 2'b00, 10'h005, 16'hA5A5});
            chk("wr_pins_fp", 64'({cen_f, wen_f, a_f, d_f}), {36'h0, 2'b00, 10'h005, 16'hA5A5});
         end
         if (k == 2) begin
            chk("rd_pins_rr", 64'({cen_r, wen_r, a_r, d_r}), {36'h0, 2'b01, 10'h005, 16'hA5A5});
         end
         if (k == 3) begin
            chk("idle_gnt", 64'({gnt_r, gnt_f}), 64'h0);
            chk("idle_pins_rr", 64'({cen_r, wen_r, a_r}), {52'h0, 2'b11, 10'h005});
            chk("idle_pins_fp", 64'({cen_f, wen_f, a_f}), {52'h0, 2'b11, 10'h005});
         end
         chk($sformatf("wr_rv_rr[%0d]", k), 64'(rv_r), (k == 4) ? 64'h0080 : 64'h0);
         chk($sformatf("wr_rv_fp[%0d]", k), 64'(rv_f), (k == 6) ? 64'h0080 : 64'h0);
         if (k == 4) chk("wr_rd_rr", 64'(rd_r), 64'hA5A5);
         if (k == 6) chk("wr_rd_fp", 64'(rd_f), 64'hA5A5);
         next_cycle();
      end

      // Preload addresses 1..3, then back-to-back reads ch1, ch2, ch1.
      drive_one(0, 1'b1, 10'h001, 16'h1111);
      next_cycle();
      drive_one(0, 1'b1, 10'h002, 16'h2222);
      next_cycle();
      drive_one(0, 1'b1, 10'h003, 16'h3333);
      next_cycle();
      for (int k = 0; k < 10; k++) begin
         if (k == 0)      drive_one(1, 1'b0, 10'h001, 16'h0000);
         else if (k == 1) drive_one(2, 1'b0, 10'h002, 16'h0000);
         else if (k == 2) drive_one(1, 1'b0, 10'h003, 16'h0000);
         else             req_i = '0;
         @(negedge clk);
         chk($sformatf("bb_rv_rr[%0d]", k), 64'(rv_r),
             (k >= 3 && k <= 5) ? 64'(bb_v[k-3]) : 64'h0);
         chk($sformatf("bb_rv_fp[%0d]", k), 64'(rv_f),
             (k >= 5 && k <= 7) ? 64'(bb_v[k-5]) : 64'h0);
         if (k >= 3 && k <= 5) chk($sformatf("bb_rd_rr[%0d]", k), 64'(rd_r), 64'(bb_d[k-3]));
         if (k >= 5 && k <= 7) chk($sformatf("bb_rd_fp[%0d]", k), 64'(rd_f), 64'(bb_d[k-5]));
         next_cycle();
      end
      idle(4);

      // Reset pulse while a ch4 read is in flight (also leaves rr pointer at 5).
      drive_one(4, 1'b0, 10'h02A, 16'h0000);
      next_cycle();
      req_i = '0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pins", 64'({cen_r, wen_r, a_r, d_r}), {36'h0, 2'b11, 10'h000, 16'h0000});
      chk("mid_rst_rv", 64'({rv_r, rv_f}), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         next_cycle();
         @(negedge clk);
         chk($sformatf("mid_rv[%0d]", k), 64'({rv_r, rv_f}), 64'h0);
      end
      next_cycle();
      req_i = 16'h0021;
      @(negedge clk);
      chk("mid_ptr_rr", 64'(gnt_r), 64'h0001);
      chk("mid_gnt_fp", 64'(gnt_f), 64'h0001);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
